// File: rtl/regfile_wb_arb.sv
// Regfile write-port controller: clears x1..x31 after reset, then round-robin arbitrates NUM_REQ requesters (REGFILE_WB_ARB_STATS_EN adds stall_cnt_o).
// Latency: one cycle from valid&ready handshake to the registered write port; one write per cycle.
// Backpressure: req_ready_o is combinational, at most one bit high, and all-zero during reset and the clear sequence.
module regfile_wb_arb #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [ADDR_W-1:0]         rd_addr_o,
  output logic [DATA_W-1:0]         rd_data_o,
  output logic                      rd_we_o,
  output logic                      busy_o
`ifdef REGFILE_WB_ARB_STATS_EN
  ,
  output logic [31:0]               stall_cnt_o
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] CLR_LAST = '1;

  typedef enum logic {ST_CLEAR, ST_ARB} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    gnt_idx;
  logic                gnt_vld;
  logic [2*NUM_REQ-1:0] rot_vld;
  logic [ADDR_W-1:0]   sel_addr, addr_d;
  logic [DATA_W-1:0]   sel_data, data_d;
  logic                we_d;
  int                  scan_idx;

  // Rotate the valid vector so bit 0 is the requester at rr_ptr; the first set bit wins.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = 0;
    rot_vld  = {req_valid_i, req_valid_i} >> rr_ptr_q;
    if (!rst_i && state_q == ST_ARB) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!gnt_vld && rot_vld[i]) begin
          gnt_vld  = 1'b1;
          scan_idx = int'(rr_ptr_q) + i;
          if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
          gnt_idx  = PTR_W'(scan_idx);
        end
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    sel_addr    = '0;
    sel_data    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_vld && gnt_idx == PTR_W'(k)) begin
        req_ready_o[k] = 1'b1;
        sel_addr       = req_addr_i[k*ADDR_W +: ADDR_W];
        sel_data       = req_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    rr_ptr_d  = rr_ptr_q;
    we_d      = 1'b0;
    addr_d    = rd_addr_o;
    data_d    = rd_data_o;
    case (state_q)
      ST_CLEAR: begin
        we_d      = 1'b1;
        addr_d    = clr_ptr_q;
        data_d    = '0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == CLR_LAST) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (gnt_vld) begin
          // x0 writes complete the handshake but never reach the regfile.
          we_d     = |sel_addr;
          addr_d   = sel_addr;
          data_d   = sel_data;
          rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= ADDR_W'(1);
      rr_ptr_q  <= '0;
      rd_we_o   <= 1'b0;
      rd_addr_o <= '0;
      rd_data_o <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      rr_ptr_q  <= rr_ptr_d;
      rd_we_o   <= we_d;
      rd_addr_o <= addr_d;
      rd_data_o <= data_d;
    end
  end

  assign busy_o = (state_q == ST_CLEAR);

`ifdef REGFILE_WB_ARB_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (state_q == ST_ARB && |(req_valid_i & ~req_ready_o) && stall_cnt_o != 32'hFFFF_FFFF) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Self-checking bench for regfile_wb_arb: directed scenarios plus a randomized run against a behavioural arbitration model.
module tb_regfile_wb_arb;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    valid;
  logic [N-1:0]    ready;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] data;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   rd_data;
  logic            rd_we;
  logic            busy;
`ifdef REGFILE_WB_ARB_STATS_EN
  logic [31:0]     stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int              rr_m;
  int              stall_m;
  logic            exp_we;
  logic [AW-1:0]   exp_addr;
  logic [DW-1:0]   exp_data;

  always #5 clk = ~clk;

  regfile_wb_arb #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (valid),
    .req_ready_o (ready),
    .req_addr_i  (addr),
    .req_data_i  (data),
    .rd_addr_o   (rd_addr),
    .rd_data_o   (rd_data),
    .rd_we_o     (rd_we),
    .busy_o      (busy)
`ifdef REGFILE_WB_ARB_STATS_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  task automatic set_req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr[k*AW +: AW] = a;
    data[k*DW +: DW] = d;
  endtask

  // First valid requester at or after rr, wrapping; -1 if none.
  function automatic int model_grant(input logic [N-1:0] v, input int rr);
    for (int j = 0; j < N; j++) begin
      int k;
      k = (rr + j) % N;
      if (((int'(v) >> k) & 1) == 1) return k;
    end
    return -1;
  endfunction

  // Entered with rst=1 at a negedge; releases reset and checks the 31 clear writes.
  task automatic run_clear(input string tag);
    rst   = 1'b0;
    valid = '1;
    #1;
    checks++;
    if (ready !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_pre: ready=%b busy=%b, want ready=000 busy=1", tag, ready, busy);
    end
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      checks++;
      if (rd_we !== 1'b1 || rd_addr !== AW'(i) || rd_data !== '0) begin
        errors++;
        $display("FAIL %s_write%0d: we=%b addr=%0d data=%h, want we=1 addr=%0d data=0", tag, i, rd_we, rd_addr, rd_data, i);
      end
      checks++;
      if (busy !== (i < 31)) begin
        errors++;
        $display("FAIL %s_busy%0d: busy=%b, want %b", tag, i, busy, (i < 31));
      end
      if (i < 31) begin
        checks++;
        if (ready !== '0) begin
          errors++;
          $display("FAIL %s_ready%0d: ready=%b, want 000", tag, i, ready);
        end
      end else begin
        valid = '0;
      end
`ifdef REGFILE_WB_ARB_STATS_EN
      checks++;
      if (stall_cnt !== 32'd0) begin
        errors++;
        $display("FAIL %s_stall%0d: stall_cnt=%0d, want 0", tag, i, stall_cnt);
      end
`endif
    end
    @(negedge clk);
    checks++;
    if (rd_we !== 1'b0 || busy !== 1'b0 || rd_addr !== 5'd31) begin
      errors++;
      $display("FAIL %s_done: we=%b busy=%b addr=%0d, want we=0 busy=0 addr=31", tag, rd_we, busy, rd_addr);
    end
    rr_m     = 0;
    stall_m  = 0;
    exp_addr = 5'd31;
    exp_data = '0;
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    valid = '1;
    for (int k = 0; k < N; k++) set_req(k, AW'($urandom_range(1, 31)), $urandom);
    repeat (5) @(negedge clk);
    checks++;
    if (rd_we !== 1'b0 || rd_addr !== '0 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset_port: we=%b addr=%0d data=%h, want 0/0/0", rd_we, rd_addr, rd_data);
    end
    checks++;
    if (busy !== 1'b1 || ready !== '0) begin
      errors++;
      $display("FAIL reset_status: busy=%b ready=%b, want busy=1 ready=000", busy, ready);
    end
    run_clear("clear");
  endtask

  task automatic test_single;
    valid = 3'b010;
    set_req(1, 5'd16, 32'd12);
    #1;
    checks++;
    if (ready !== 3'b010) begin
      errors++;
      $display("FAIL single_ready: ready=%b, want 010", ready);
    end
    @(negedge clk);
    valid = '0;
    checks++;
    if (rd_we !== 1'b1 || rd_addr !== 5'd16 || rd_data !== 32'd12) begin
      errors++;
      $display("FAIL single_write: we=%b addr=%0d data=%0d, want 1/16/12", rd_we, rd_addr, rd_data);
    end
    @(negedge clk);
    checks++;
    if (rd_we !== 1'b0 || rd_addr !== 5'd16 || rd_data !== 32'd12) begin
      errors++;
      $display("FAIL single_idle: we=%b addr=%0d data=%0d, want 0/16/12", rd_we, rd_addr, rd_data);
    end
    rr_m = 2;
  endtask

  task automatic test_round_robin;
    logic [DW-1:0] d [N];
    // Grant requester 2 alone so the pointer wraps to 0.
    valid = 3'b100;
    set_req(2, 5'd3, 32'h33);
    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      valid = '1;
      for (int k = 0; k < N; k++) begin
        d[k] = $urandom;
        set_req(k, AW'(4 + c), d[k]);
      end
      #1;
      checks++;
      if (ready !== N'(1 << (c % N))) begin
        errors++;
        $display("FAIL rr_grant%0d: ready=%b, want %b", c, ready, N'(1 << (c % N)));
      end
      @(negedge clk);
      checks++;
      if (rd_we !== 1'b1 || rd_addr !== AW'(4 + c) || rd_data !== d[c % N]) begin
        errors++;
        $display("FAIL rr_write%0d: we=%b addr=%0d data=%h, want 1/%0d/%h", c, rd_we, rd_addr, rd_data, 4 + c, d[c % N]);
      end
    end
    valid = '0;
    rr_m  = 0;
  endtask

  task automatic test_x0;
    valid = 3'b001;
    set_req(0, 5'd0, 32'hDEADBEEF);
    #1;
    checks++;
    if (ready !== 3'b001) begin
      errors++;
      $display("FAIL x0_ready: ready=%b, want 001", ready);
    end
    @(negedge clk);
    checks++;
    if (rd_we !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL x0_write: we=%b addr=%0d data=%h, want 0/0/deadbeef", rd_we, rd_addr, rd_data);
    end
    valid = 3'b011;
    set_req(0, 5'd6, 32'h66);
    set_req(1, 5'd7, 32'h77);
    #1;
    checks++;
    if (ready !== 3'b010) begin
      errors++;
      $display("FAIL x0_rr_advance: ready=%b, want 010", ready);
    end
    @(negedge clk);
    valid = '0;
    checks++;
    if (rd_we !== 1'b1 || rd_addr !== 5'd7 || rd_data !== 32'h77) begin
      errors++;
      $display("FAIL x0_next_write: we=%b addr=%0d data=%h, want 1/7/77", rd_we, rd_addr, rd_data);
    end
  endtask

  task automatic test_reset_mid;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (rd_we !== 1'b1 || rd_addr !== 5'd10) begin
      errors++;
      $display("FAIL mid_clear_pos: we=%b addr=%0d, want 1/10", rd_we, rd_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rd_we !== 1'b0 || busy !== 1'b1 || ready !== '0) begin
      errors++;
      $display("FAIL mid_clear_squash: we=%b busy=%b ready=%b, want 0/1/000", rd_we, busy, ready);
    end
    run_clear("restart");
    valid = 3'b001;
    set_req(0, 5'd9, 32'h99);
    @(negedge clk);
    checks++;
    if (rd_we !== 1'b1 || rd_addr !== 5'd9) begin
      errors++;
      $display("FAIL mid_arb_write: we=%b addr=%0d, want 1/9", rd_we, rd_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ready !== '0) begin
      errors++;
      $display("FAIL mid_arb_ready: ready=%b, want 000", ready);
    end
    @(negedge clk);
    valid = '0;
    checks++;
    if (rd_we !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_arb_squash: we=%b busy=%b, want 0/1", rd_we, busy);
    end
    run_clear("post_arb");
  endtask

  task automatic test_random;
    bit            pv [N];
    logic [AW-1:0] pa [N];
    logic [DW-1:0] pd [N];
    logic [N-1:0]  exp_rdy;
    int            g;
    for (int k = 0; k < N; k++) pv[k] = 1'b0;
    for (int c = 0; c < 300; c++) begin
      valid = '0;
      for (int k = 0; k < N; k++) begin
        if (pv[k] && $urandom_range(0, 7) == 0) begin
          pv[k] = 1'b0;
        end else if (!pv[k]) begin
          pv[k] = ($urandom_range(0, 2) != 0);
          pa[k] = AW'($urandom_range(0, 31));
          pd[k] = $urandom;
        end
        if (pv[k]) valid = valid | N'(1 << k);
        set_req(k, pa[k], pd[k]);
      end
      g = model_grant(valid, rr_m);
      exp_rdy = (g < 0) ? '0 : N'(1 << g);
      #1;
      checks++;
      if (ready !== exp_rdy) begin
        errors++;
        $display("FAIL rand_ready%0d: ready=%b, want %b", c, ready, exp_rdy);
      end
      if ((valid & ~exp_rdy) != '0) stall_m++;
      if (g >= 0) begin
        exp_we   = (pa[g] != '0);
        exp_addr = pa[g];
        exp_data = pd[g];
        rr_m     = (g + 1) % N;
        pv[g]    = 1'b0;
      end else begin
        exp_we = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (rd_we !== exp_we || rd_addr !== exp_addr || rd_data !== exp_data) begin
        errors++;
        $display("FAIL rand_write%0d: we=%b addr=%0d data=%h, want %b/%0d/%h", c, rd_we, rd_addr, rd_data, exp_we, exp_addr, exp_data);
      end
    end
    valid = '0;
`ifdef REGFILE_WB_ARB_STATS_EN
    checks++;
    if (stall_cnt !== 32'(stall_m)) begin
      errors++;
      $display("FAIL rand_stall: stall_cnt=%0d, want %0d", stall_cnt, stall_m);
    end
`endif
  endtask

`ifdef REGFILE_WB_ARB_STATS_EN
  task automatic test_stats;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL stats_reset: stall_cnt=%0d, want 0", stall_cnt);
    end
    run_clear("stats_clear");
    valid = '1;
    for (int k = 0; k < N; k++) set_req(k, AW'(k + 1), $urandom);
    repeat (4) @(negedge clk);
    valid = '0;
    checks++;
    if (stall_cnt !== 32'd4) begin
      errors++;
      $display("FAIL stats_count: stall_cnt=%0d, want 4", stall_cnt);
    end
    @(negedge clk);
    checks++;
    if (stall_cnt !== 32'd4) begin
      errors++;
      $display("FAIL stats_hold_idle: stall_cnt=%0d, want 4", stall_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL stats_rst: stall_cnt=%0d, want 0", stall_cnt);
    end
    run_clear("stats_reclear");
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    valid    = '0;
    addr     = '0;
    data     = '0;
    rr_m     = 0;
    stall_m  = 0;
    exp_we   = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_x0();
    test_reset_mid();
    test_random();
`ifdef REGFILE_WB_ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
